// File: rtl/csr_pkg.sv
// Shared CSR definitions: architectural addresses and helpers used by the CSR register blocks.
package csr_pkg;

  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_SEPC = 12'h141;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_WRITE
  } stack_op_e;

  // Lowest PC bit that can be non-zero for a given instruction alignment.
  function automatic int unsigned align_lsb(input int unsigned ialign);
    return (ialign == 16) ? 1 : 2;
  endfunction

endpackage

// File: rtl/csrfield.sv
// Generic CSR field: a register updated with (value | set) & ~clear when enabled.
module csrfield #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] set_i,
  input  logic [WIDTH-1:0] clear_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] value_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      value_reg <= '0;
    end else if (en_i) begin
      value_reg <= (value_reg | set_i) & ~clear_i;
    end
  end

  assign value_o = value_reg;

endmodule

// File: rtl/csr_epc_stack.sv
// Exception PC CSR with a small stack of nested-trap entries: traps push, mret pops,
// CSR accesses modify only the top entry.
module csr_epc_stack
  import csr_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IALIGN  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter logic [11:0] ADDRESS = CSR_MEPC
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [11:0]                addr_i,
  input  logic [XLEN-1:0]            set_i,
  input  logic [XLEN-1:0]            clear_i,
  output logic                       ack_o,
  output logic [XLEN-1:0]            value_o,
  input  logic                       exception_detected_i,
  input  logic [XLEN-1:0]            pc_last_i,
  input  logic                       mret_i,
  input  logic                       c_enabled_i,
  output logic [XLEN-1:0]            ret_pc_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overflow_o
);

  localparam int unsigned LSB = align_lsb(IALIGN);
  localparam int unsigned SW  = XLEN - LSB;
  localparam int unsigned LW  = $clog2(DEPTH + 1);

  stack_op_e     op;
  logic          pop_shift;
  logic          level_full;
  logic [LW-1:0] level_reg;
  logic          overflow_reg;
  logic [SW-1:0] top_value;
  logic [SW-1:0] next_below;
  logic [SW-1:0] pc_stored;
  logic          field_en;
  logic [SW-1:0] field_set;
  logic [SW-1:0] field_clear;

  assign ack_o      = en_i && (addr_i == ADDRESS);
  assign pc_stored  = pc_last_i[XLEN-1:LSB];
  assign level_full = (int'(level_reg) == DEPTH);
  // A pop only moves data when another entry sits below the top.
  assign pop_shift  = (op == OP_POP) && (int'(level_reg) >= 2);

  always_comb begin
    op = OP_NONE;
    if (exception_detected_i) begin
      op = OP_PUSH;
    end else if (mret_i) begin
      op = OP_POP;
    end else if (ack_o) begin
      op = OP_WRITE;
    end
  end

  // Push/pop load a whole new value through the field's set/clear pair.
  always_comb begin
    field_en    = 1'b0;
    field_set   = '0;
    field_clear = '0;
    case (op)
      OP_PUSH: begin
        field_en    = 1'b1;
        field_set   = pc_stored;
        field_clear = ~pc_stored;
      end
      OP_POP: begin
        field_en    = pop_shift;
        field_set   = next_below;
        field_clear = ~next_below;
      end
      OP_WRITE: begin
        field_en    = 1'b1;
        field_set   = set_i[XLEN-1:LSB];
        field_clear = clear_i[XLEN-1:LSB];
      end
      default: ;
    endcase
  end

  csrfield #(
    .WIDTH (SW)
  ) u_top (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (field_en),
    .set_i   (field_set),
    .clear_i (field_clear),
    .value_o (top_value)
  );

  generate
    if (DEPTH > 1) begin : g_lower
      // lower_reg[0] is the entry directly below the top.
      logic [SW-1:0] lower_reg [DEPTH-1];

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          for (int k = 0; k < DEPTH - 1; k++) begin
            lower_reg[k] <= '0;
          end
        end else if (op == OP_PUSH) begin
          lower_reg[0] <= top_value;
          for (int k = 1; k < DEPTH - 1; k++) begin
            lower_reg[k] <= lower_reg[k-1];
          end
        end else if (pop_shift) begin
          for (int k = 0; k < DEPTH - 2; k++) begin
            lower_reg[k] <= lower_reg[k+1];
          end
          lower_reg[DEPTH-2] <= '0;
        end
      end

      assign next_below = lower_reg[0];
    end else begin : g_no_lower
      assign next_below = '0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (op == OP_PUSH) begin
      if (level_full) begin
        overflow_reg <= 1'b1;
      end else begin
        level_reg <= level_reg + 1'b1;
      end
    end else if (op == OP_POP) begin
      if (pop_shift) begin
        level_reg <= level_reg - 1'b1;
      end else begin
        level_reg    <= '0;
        overflow_reg <= 1'b0;
      end
    end
  end

  // Stored bit 1 survives; it is only hidden while compressed instructions are off.
  always_comb begin
    value_o = {top_value, {LSB{1'b0}}};
    if (!c_enabled_i) begin
      value_o[1] = 1'b0;
    end
  end

  assign ret_pc_o   = value_o;
  assign level_o    = level_reg;
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_csr_epc_stack.sv
// Directed bench for csr_epc_stack: default configuration plus an IALIGN=16 instance
// sharing the same stimulus.
module tb_csr_epc_stack;
  import csr_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] val;
    logic [2:0]  lvl;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] set_m = '0;
  logic [31:0] clr_m = '0;
  logic        exc = 1'b0;
  logic [31:0] pc_last = '0;
  logic        mret = 1'b0;
  logic        c_en = 1'b1;

  logic        ack, ack16;
  logic [31:0] value, value16, ret_pc, ret_pc16;
  logic [2:0]  level, level16;
  logic        ovf, ovf16;

  int   n_vec = 0;
  int   n_miss = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  csr_epc_stack #(.XLEN(32), .IALIGN(32), .DEPTH(4), .ADDRESS(CSR_MEPC)) dut (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .addr_i(addr), .set_i(set_m), .clear_i(clr_m),
    .ack_o(ack), .value_o(value), .exception_detected_i(exc), .pc_last_i(pc_last),
    .mret_i(mret), .c_enabled_i(c_en), .ret_pc_o(ret_pc), .level_o(level), .overflow_o(ovf)
  );

  csr_epc_stack #(.XLEN(32), .IALIGN(16), .DEPTH(4), .ADDRESS(CSR_MEPC)) dut16 (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .addr_i(addr), .set_i(set_m), .clear_i(clr_m),
    .ack_o(ack16), .value_o(value16), .exception_detected_i(exc), .pc_last_i(pc_last),
    .mret_i(mret), .c_enabled_i(c_en), .ret_pc_o(ret_pc16), .level_o(level16), .overflow_o(ovf16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock of stimulus: expectation queued at drive time, compared after the edge.
  task automatic step(input string tag, input logic e, input logic m, input logic w,
                      input logic [11:0] a, input logic [31:0] pc, input logic [31:0] s,
                      input logic [31:0] c, input logic [31:0] ev, input logic [2:0] el,
                      input logic eo, input logic eack);
    exp_t x;
    @(negedge clk);
    exc = e; mret = m; en = w; addr = a; pc_last = pc; set_m = s; clr_m = c;
    sb.push_back('{tag, ev, el, eo});
    #1 chk({tag, ".ack"}, 32'(ack), 32'(eack));
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, ".value"}, value, x.val);
    chk({x.tag, ".ret_pc"}, ret_pc, x.val);
    chk({x.tag, ".level"}, 32'(level), 32'(x.lvl));
    chk({x.tag, ".ovf"}, 32'(ovf), 32'(x.ovf));
    $display("step %s: value=%h level=%0d ovf=%0b", x.tag, value, level, ovf);
    exc = 1'b0; mret = 1'b0; en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.value", value, 32'h0);
    chk("rst.level", 32'(level), 32'h0);
    chk("rst.ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // CSR writes: set/clear masks, unstored low bits, address decode
    step("wr_set",   0, 0, 1, 12'h341, 0, 32'h8000_0007, 0, 32'h8000_0004, 0, 0, 1);
    step("wr_badad", 0, 0, 1, 12'h342, 0, 32'hFFFF_FFFF, 0, 32'h8000_0004, 0, 0, 0);
    step("wr_clr",   0, 0, 1, 12'h341, 0, 0, 32'h8000_0000, 32'h0000_0004, 0, 0, 1);
    step("wr_clr2",  0, 0, 1, 12'h341, 0, 0, 32'h0000_0004, 32'h0, 0, 0, 1);

    // Nested pushes and pops, including pop at level 1 keeping the value
    step("push100", 1, 0, 0, 0, 32'h100, 0, 0, 32'h100, 1, 0, 0);
    step("push200", 1, 0, 0, 0, 32'h200, 0, 0, 32'h200, 2, 0, 0);
    step("push300", 1, 0, 0, 0, 32'h300, 0, 0, 32'h300, 3, 0, 0);
    step("pop_a",   0, 1, 0, 0, 0, 0, 0, 32'h200, 2, 0, 0);
    step("pop_b",   0, 1, 0, 0, 0, 0, 0, 32'h100, 1, 0, 0);
    step("pop_c",   0, 1, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0);

    // Overflow: fifth push drops the bottom entry, final pop clears the flag
    step("ovpush10", 1, 0, 0, 0, 32'h10, 0, 0, 32'h10, 1, 0, 0);
    step("ovpush20", 1, 0, 0, 0, 32'h20, 0, 0, 32'h20, 2, 0, 0);
    step("ovpush30", 1, 0, 0, 0, 32'h30, 0, 0, 32'h30, 3, 0, 0);
    step("ovpush40", 1, 0, 0, 0, 32'h40, 0, 0, 32'h40, 4, 0, 0);
    step("ovpush50", 1, 0, 0, 0, 32'h50, 0, 0, 32'h50, 4, 1, 0);
    step("ovpop1",   0, 1, 0, 0, 0, 0, 0, 32'h40, 3, 1, 0);
    step("ovpop2",   0, 1, 0, 0, 0, 0, 0, 32'h30, 2, 1, 0);
    step("ovpop3",   0, 1, 0, 0, 0, 0, 0, 32'h20, 1, 1, 0);
    step("ovpop4",   0, 1, 0, 0, 0, 0, 0, 32'h20, 0, 0, 0);

    // Priority: exception beats mret and write; write leaves level alone
    step("all3",    1, 1, 1, 12'h341, 32'h400, 32'hF000, 0, 32'h400, 1, 0, 1);
    step("wr_lvl1", 0, 0, 1, 12'h341, 0, 32'h1003, 0, 32'h1400, 1, 0, 1);
    step("mret_wr", 0, 1, 1, 12'h341, 0, 32'h0F00, 0, 32'h1400, 0, 0, 1);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.value", value, 32'h0);
    chk("arst.ret_pc", ret_pc, 32'h0);
    chk("arst.level", 32'(level), 32'h0);
    chk("arst.value16", value16, 32'h0);

    // Reset held across a coincident push and write
    @(negedge clk);
    exc = 1'b1; en = 1'b1; addr = 12'h341; pc_last = 32'h777C; set_m = 32'hFF00;
    @(posedge clk);
    #1;
    chk("rsthold.value", value, 32'h0);
    chk("rsthold.level", 32'(level), 32'h0);
    @(negedge clk);
    exc = 1'b0; en = 1'b0; rst_n = 1'b1;

    // Half-word alignment and the c_enabled view of bit 1
    step("c_push102", 1, 0, 0, 0, 32'h102, 0, 0, 32'h100, 1, 0, 0);
    chk("c16.on", value16, 32'h102);
    c_en = 1'b0;
    #1;
    chk("c16.off", value16, 32'h100);
    chk("c16.off_ret", ret_pc16, 32'h100);
    c_en = 1'b1;
    #1;
    chk("c16.on2", value16, 32'h102);
    step("c_push103", 1, 0, 0, 0, 32'h103, 0, 0, 32'h100, 2, 0, 0);
    chk("c16.bit0", value16, 32'h102);
    chk("c16.level", 32'(level16), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/csr_epc_stack.md
CSR_EPC_STACK -- requirements
Module: csr_epc_stack

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the register width.
REQ-002 The module SHALL have parameter IALIGN, default 32, legal values 16 or 32, giving the instruction alignment.
REQ-003 The module SHALL have parameter DEPTH, default 4, legal range 1..16, giving the number of nested-trap entries.
REQ-004 The module SHALL have parameter ADDRESS, default 12'h341, giving the CSR address decoded.
REQ-005 The module SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-006 The module SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The module SHALL have port en_i, input, 1 bit: CSR access strobe.
REQ-008 The module SHALL have port addr_i, input, 12 bits: CSR address.
REQ-009 The module SHALL have ports set_i and clear_i, input, XLEN bits each: bit-set mask and bit-clear mask.
REQ-010 The module SHALL have port ack_o, output, 1 bit: address-match acknowledge.
REQ-011 The module SHALL have port value_o, output, XLEN bits: architectural read value of the top entry.
REQ-012 The module SHALL have port exception_detected_i, input, 1 bit: trap-entry strobe.
REQ-013 The module SHALL have port pc_last_i, input, XLEN bits: PC of the trapping instruction.
REQ-014 The module SHALL have port mret_i, input, 1 bit: trap-return strobe.
REQ-015 The module SHALL have port c_enabled_i, input, 1 bit: compressed ISA currently enabled.
REQ-016 The module SHALL have port ret_pc_o, output, XLEN bits: return target, equal to value_o.
REQ-017 The module SHALL have port level_o, output, $clog2(DEPTH+1) bits: count of valid nested entries.
REQ-018 The module SHALL have port overflow_o, output, 1 bit: sticky flag indicating a nesting overflow.

Function
REQ-019 ack_o SHALL equal en_i && (addr_i == ADDRESS), combinationally.
REQ-020 The entries SHALL store bits [XLEN-1:1] when IALIGN=16, or bits [XLEN-1:2] when IALIGN=32; unstored bits SHALL read as 0.
REQ-021 value_o SHALL be the top entry with bit 0 forced to 0, and with bit 1 forced to 0 whenever c_enabled_i=0; the stored bit 1 SHALL be retained.
REQ-022 Each cycle SHALL perform exactly one update, with priority exception_detected_i > mret_i > CSR write; all results SHALL be visible the cycle after the event.
REQ-023 Push (exception_detected_i=1): entry[k] <= entry[k-1] for k=1..DEPTH-1; top <= pc_last_i masked per REQ-020; level_o increments, saturating at DEPTH.
REQ-024 Push when level_o == DEPTH: the bottom entry SHALL be discarded and overflow_o SHALL be set to 1.
REQ-025 Pop (mret_i=1, no exception) when level_o >= 2: entry[k] <= entry[k+1]; bottom <= 0; level_o decrements.
REQ-026 Pop when level_o <= 1: the top entry SHALL be unchanged and level_o SHALL become 0.
REQ-027 overflow_o SHALL clear when a pop leaves level_o at 0; otherwise it SHALL hold its value.
REQ-028 CSR write (ack, no exception, no mret): top <= (top | set_i) & ~clear_i, masked per REQ-020; the other entries and level_o SHALL be unchanged.
REQ-029 Exception coincident with an ack: ack_o SHALL still assert and the write SHALL be discarded.
REQ-030 Exception coincident with mret: the mret SHALL be ignored.
REQ-031 With DEPTH=1: push overwrites top, and a pop leaves the value intact.

Reset
REQ-032 While rst_i=0, asynchronously: all entries SHALL be 0, level_o SHALL be 0, overflow_o SHALL be 0, and value_o and ret_pc_o SHALL be 0.
REQ-033 Deassertion of rst_i SHALL be synchronized externally; the first update SHALL occur on the first rising edge with rst_i=1.
REQ-034 Reset asserted mid-push or mid-write SHALL override that operation.

Structure
REQ-035 CSR address constants (MEPC 12'h341, SEPC 12'h141) SHALL live in shared package csr_pkg.
REQ-036 The top entry SHALL instantiate the existing csrfield sub-module (WIDTH = stored width), driven with set = new value and clear = ~new value on push and pop.
REQ-037 The lower entries SHALL be a plain register array in this module.

Verification
REQ-038 XLEN=32, IALIGN=32, DEPTH=4: write addr 12'h341 set=32'h8000_0007 -> ack_o=1; next cycle value_o=32'h8000_0004.
REQ-039 Three pushes with pc 32'h100, 32'h200, 32'h300 -> level_o=3, value_o=32'h300; pop -> value_o=32'h200, level_o=2.
REQ-040 Five pushes with pc 0x10, 0x20, 0x30, 0x40, 0x50 -> level_o=4, overflow_o=1; four pops -> value_o=0x20, level_o=0, overflow_o=0.
REQ-041 IALIGN=16: push pc 32'h102 with c_enabled_i=1 -> value_o=32'h102; drop c_enabled_i to 0 -> value_o=32'h100; raise to 1 -> 32'h102.
REQ-042 Exception, mret and ack in the same cycle with pc 32'h400 -> ack_o=1; next cycle value_o=32'h400 and level_o incremented; assert rst_i=0 mid-cycle -> all outputs 0 immediately.
